// File: rtl/n64_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : n64_pkg
//  Description : Shared definitions for the N64 joybus console host:
//                command codes, reply lengths, FSM state encoding and the
//                protocol timing multiples (in microseconds).
//  Revision    : 1.0 - initial release
// ============================================================================
package n64_pkg;

    // Command codes understood by a standard controller
    localparam logic [7:0] CMD_INFO  = 8'h00;
    localparam logic [7:0] CMD_POLL  = 8'h01;
    localparam logic [7:0] CMD_RESET = 8'hFF;

    // Pulse timing in microseconds; scaled by CLKS_PER_US at the use site
    localparam int BIT_US    = 4;   // full bit cell
    localparam int SHORT_US  = 1;   // low time of a '1' and of the stop bit
    localparam int LONG_US   = 3;   // low time of a '0'
    localparam int THRESH_US = 2;   // RX decision point between '1' and '0'

    // Host FSM state encoding
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_TX_BIT  = 3'd1;
    localparam state_t ST_TX_STOP = 3'd2;
    localparam state_t ST_RX_WAIT = 3'd3;
    localparam state_t ST_RX_LOW  = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

    // Number of reply bytes expected for a command; unknown commands get none
    function automatic logic [2:0] reply_len(input logic [7:0] cmd);
        logic [2:0] len;
        case (cmd)
            CMD_INFO, CMD_RESET: len = 3'd3;
            CMD_POLL:            len = 3'd4;
            default:             len = 3'd0;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/n64_pulse_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : n64_pulse_decoder
//  Description : Receive front end for the joybus line. Synchronises the
//                shared line, detects edges, measures each low pulse and the
//                high time between pulses, and classifies pulses as bits.
//  Ports       : sample_clk, rst_n      - clock, async active-low reset
//                data_rx                - raw line level (asynchronous)
//                arm                    - host is receiving; counters held
//                                         clear while low
//                fall                   - qualified falling edge (1 cycle)
//                bit_valid / bit_value  - end of a low pulse and its value
//                low_cycles             - length of current/last low pulse
//                line_idle_cycles       - high time since arm / last pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module n64_pulse_decoder
    import n64_pkg::*;
#(
    parameter int CLKS_PER_US = 2,
    parameter int TIMEOUT_US  = 64,
    parameter int CNT_W       = $clog2(TIMEOUT_US * CLKS_PER_US + 1)
) (
    input  logic             sample_clk,
    input  logic             rst_n,
    input  logic             data_rx,
    input  logic             arm,
    output logic             fall,
    output logic             bit_valid,
    output logic             bit_value,
    output logic [CNT_W-1:0] low_cycles,
    output logic [CNT_W-1:0] line_idle_cycles
);

    localparam logic [CNT_W-1:0] c_LIMIT  = CNT_W'(TIMEOUT_US * CLKS_PER_US);
    localparam logic [CNT_W-1:0] c_THRESH = CNT_W'(THRESH_US * CLKS_PER_US);

    logic             r_meta, r_sync, r_prev;
    logic             r_high_seen;
    logic             r_low_active;
    logic [CNT_W-1:0] r_low;
    logic [CNT_W-1:0] r_idle;
    logic             w_fall, w_rise;

    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= data_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // The synchronised line still shows the host's own stop bit for a couple
    // of cycles after arming; a falling edge only counts once the line has
    // been seen high while armed, so that echo is never mistaken for a reply.
    assign w_rise = ~r_prev & r_sync;
    assign w_fall = r_high_seen & r_prev & ~r_sync;

    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high_seen  <= 1'b0;
            r_low_active <= 1'b0;
            r_low        <= '0;
            r_idle       <= '0;
        end else begin
            r_high_seen <= arm & (r_high_seen | r_sync);

            if (!arm)        r_low_active <= 1'b0;
            else if (w_fall) r_low_active <= 1'b1;
            else if (w_rise) r_low_active <= 1'b0;

            // Low time saturates at the timeout limit
            if (!arm)
                r_low <= '0;
            else if (w_fall)
                r_low <= CNT_W'(1);
            else if (r_low_active && !r_sync && r_low != c_LIMIT)
                r_low <= r_low + 1'b1;

            // High time restarts at every pulse; saturates at the limit
            if (!arm || w_fall || r_low_active)
                r_idle <= '0;
            else if (r_idle != c_LIMIT)
                r_idle <= r_idle + 1'b1;
        end
    end

    assign fall             = w_fall;
    assign bit_valid        = r_low_active & w_rise;
    assign bit_value        = (r_low < c_THRESH);
    assign low_cycles       = r_low;
    assign line_idle_cycles = r_idle;

endmodule
`default_nettype wire

// File: rtl/n64_console_host.sv
`default_nettype none
// ============================================================================
//  Module      : n64_console_host
//  Description : Console-side joybus initiator. Sends one command byte plus
//                stop bit on the open-drain line, then collects the
//                controller's reply bytes and stop bit.
//  Ports       : sample_clk, rst_n          - clock, async active-low reset
//                cmd_valid/cmd_ready/cmd_byte - command handshake
//                data_tx                    - 0 pulls line low, 1 releases
//                data_rx                    - shared line level
//                busy                       - transaction in progress
//                rsp_valid                  - one-cycle completion pulse
//                rsp_data/rsp_len/rsp_timeout - reply, held until next accept
//  Revision    : 1.0 - initial release
// ============================================================================
module n64_console_host
    import n64_pkg::*;
#(
    parameter int CLKS_PER_US = 2,
    parameter int TIMEOUT_US  = 64
) (
    input  logic        sample_clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_byte,
    output logic        data_tx,
    input  logic        data_rx,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [2:0]  rsp_len,
    output logic        rsp_timeout
);

    localparam int c_CNT_W  = $clog2(TIMEOUT_US * CLKS_PER_US + 1);
    localparam int c_TICK_W = $clog2(BIT_US * CLKS_PER_US);

    localparam logic [c_CNT_W-1:0]  c_LIMIT     = c_CNT_W'(TIMEOUT_US * CLKS_PER_US);
    localparam logic [c_CNT_W-1:0]  c_LIMIT_M1  = c_CNT_W'(TIMEOUT_US * CLKS_PER_US - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(BIT_US * CLKS_PER_US - 1);
    localparam logic [c_TICK_W-1:0] c_STOP_LAST = c_TICK_W'(SHORT_US * CLKS_PER_US - 1);
    localparam logic [c_TICK_W-1:0] c_SHORT     = c_TICK_W'(SHORT_US * CLKS_PER_US);
    localparam logic [c_TICK_W-1:0] c_LONG      = c_TICK_W'(LONG_US * CLKS_PER_US);

    state_t              r_state, w_state_nxt;
    logic [c_TICK_W-1:0] r_tick;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_tx_sr;
    logic [2:0]          r_exp_len;
    logic [6:0]          r_rx_sr;     // partial byte; only whole bytes reach rsp_data
    logic [2:0]          r_rx_cnt;
    logic [31:0]         r_rsp_data;
    logic [2:0]          r_rsp_len;
    logic                r_rsp_timeout;

    logic                w_accept, w_tick_end, w_stop_end, w_arm;
    logic                w_fall, w_bit_valid, w_bit_value;
    logic [c_CNT_W-1:0]  w_low, w_idle;

    assign w_accept   = cmd_valid && (r_state == ST_IDLE);
    assign w_tick_end = (r_tick == c_TICK_LAST);
    assign w_stop_end = (r_tick == c_STOP_LAST);
    assign w_arm      = (r_state == ST_RX_WAIT) || (r_state == ST_RX_LOW);

    n64_pulse_decoder #(
        .CLKS_PER_US (CLKS_PER_US),
        .TIMEOUT_US  (TIMEOUT_US),
        .CNT_W       (c_CNT_W)
    ) u_decoder (
        .sample_clk       (sample_clk),
        .rst_n            (rst_n),
        .data_rx          (data_rx),
        .arm              (w_arm),
        .fall             (w_fall),
        .bit_valid        (w_bit_valid),
        .bit_value        (w_bit_value),
        .low_cycles       (w_low),
        .line_idle_cycles (w_idle)
    );

    // ---------------- state register ----------------
    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---------------- next-state logic ----------------
    // The idle timer is compared one short of the limit so DONE begins on the
    // very edge at which the line has been high for the full timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept) w_state_nxt = ST_TX_BIT;
            ST_TX_BIT:  if (w_tick_end && r_bit_idx == 3'd7) w_state_nxt = ST_TX_STOP;
            ST_TX_STOP: if (w_stop_end) w_state_nxt = (r_exp_len == 3'd0) ? ST_DONE : ST_RX_WAIT;
            ST_RX_WAIT: begin
                if (w_fall)                    w_state_nxt = ST_RX_LOW;
                else if (w_idle == c_LIMIT_M1) w_state_nxt = ST_DONE;
            end
            ST_RX_LOW: begin
                // Once all bytes are in, the next pulse is the controller stop bit
                if (w_bit_valid)           w_state_nxt = (r_rsp_len == r_exp_len) ? ST_DONE : ST_RX_WAIT;
                else if (w_low == c_LIMIT) w_state_nxt = ST_DONE;
            end
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick        <= '0;
            r_bit_idx     <= '0;
            r_tx_sr       <= '0;
            r_exp_len     <= '0;
            r_rx_sr       <= '0;
            r_rx_cnt      <= '0;
            r_rsp_data    <= '0;
            r_rsp_len     <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_tx_sr       <= cmd_byte;
                    r_exp_len     <= reply_len(cmd_byte);
                    r_bit_idx     <= '0;
                    r_tick        <= '0;
                    r_rx_cnt      <= '0;
                    r_rsp_data    <= '0;
                    r_rsp_len     <= '0;
                    r_rsp_timeout <= 1'b0;
                end
                ST_TX_BIT: begin
                    if (w_tick_end) begin
                        r_tick    <= '0;
                        r_bit_idx <= r_bit_idx + 1'b1;
                        r_tx_sr   <= {r_tx_sr[6:0], 1'b0};
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_TX_STOP: r_tick <= w_stop_end ? '0 : r_tick + 1'b1;
                ST_RX_WAIT: if (!w_fall && w_idle == c_LIMIT_M1) r_rsp_timeout <= 1'b1;
                ST_RX_LOW: begin
                    if (w_bit_valid) begin
                        if (r_rsp_len != r_exp_len) begin
                            r_rx_sr  <= {r_rx_sr[5:0], w_bit_value};
                            r_rx_cnt <= r_rx_cnt + 1'b1;
                            if (r_rx_cnt == 3'd7) begin
                                r_rsp_data <= {r_rsp_data[23:0], r_rx_sr, w_bit_value};
                                r_rsp_len  <= r_rsp_len + 1'b1;
                            end
                        end
                    end else if (w_low == c_LIMIT) begin
                        r_rsp_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    // Combinational from state so an asynchronous reset releases the line at once.
    always_comb begin
        data_tx   = 1'b1;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE:    cmd_ready = 1'b1;
            ST_TX_BIT: begin
                busy    = 1'b1;
                data_tx = (r_tick >= (r_tx_sr[7] ? c_SHORT : c_LONG));
            end
            ST_TX_STOP: begin
                busy    = 1'b1;
                data_tx = 1'b0;
            end
            ST_RX_WAIT, ST_RX_LOW: busy = 1'b1;
            ST_DONE:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rsp_data    = r_rsp_data;
    assign rsp_len     = r_rsp_len;
    assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_n64_console_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_n64_console_host
//  Description : Directed self-checking bench for n64_console_host. A simple
//                controller model pulls the shared line low to reply.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_n64_console_host;

    logic        sample_clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_byte;
    logic        data_tx;
    wire         data_rx;
    logic        busy;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_len;
    logic        rsp_timeout;
    logic        ctrl_low;

    int n_cmp = 0;
    int n_bad = 0;

    // Open-drain line: low if either side pulls
    assign data_rx = data_tx & ~ctrl_low;

    always #5 sample_clk = ~sample_clk;

    n64_console_host #(
        .CLKS_PER_US (2),
        .TIMEOUT_US  (64)
    ) dut (
        .sample_clk  (sample_clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_byte    (cmd_byte),
        .data_tx     (data_tx),
        .data_rx     (data_rx),
        .busy        (busy),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_len     (rsp_len),
        .rsp_timeout (rsp_timeout)
    );

    task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected data_tx for cycles 0..66 after accept (U=2: bit cell 8 cycles)
    function automatic logic [66:0] exp_wave(input logic [7:0] cmd);
        logic [66:0] w;
        int idx;
        w = '1;
        idx = 0;
        for (int b = 7; b >= 0; b--) begin
            for (int k = 0; k < 8; k++) begin
                w[idx] = (k >= (cmd[b] ? 2 : 6));
                idx++;
            end
        end
        w[64] = 1'b0;
        w[65] = 1'b0;
        w[66] = 1'b1;
        return w;
    endfunction

    // Issue a command from an idle negedge; returns at the negedge of cycle 66
    task automatic run_tx(input logic [7:0] cmd, input bit hold_valid,
                          output logic [66:0] wave, output bit hold_ok);
        hold_ok = 1'b1;
        cmd_valid = 1'b1;
        cmd_byte  = cmd;
        for (int i = 0; i <= 66; i++) begin
            @(negedge sample_clk);
            if (i == 0) begin
                if (hold_valid) cmd_byte = 8'h01;
                else            cmd_valid = 1'b0;
            end
            wave[i] = data_tx;
            if (busy !== 1'b1 || cmd_ready !== 1'b0) hold_ok = 1'b0;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic ctrl_bit(input logic b);
        ctrl_low = 1'b1;
        repeat (b ? 2 : 6) @(negedge sample_clk);
        ctrl_low = 1'b0;
        repeat (b ? 6 : 2) @(negedge sample_clk);
    endtask

    task automatic ctrl_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) ctrl_bit(v[i]);
    endtask

    task automatic ctrl_stop();
        ctrl_low = 1'b1;
        repeat (2) @(negedge sample_clk);
        ctrl_low = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (n <= max && !seen) begin
            if (rsp_valid === 1'b1) seen = 1'b1;
            else begin
                @(negedge sample_clk);
                n++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [66:0] wave;
        bit          hold_ok;
        bit          seen;
        int          n;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
        ctrl_low  = 1'b0;
        repeat (3) @(negedge sample_clk);

        // ---- reset state ----
        check("rst_data_tx",     67'(data_tx),     67'd1);
        check("rst_cmd_ready",   67'(cmd_ready),   67'd1);
        check("rst_busy",        67'(busy),        67'd0);
        check("rst_rsp_valid",   67'(rsp_valid),   67'd0);
        check("rst_rsp_data",    67'(rsp_data),    67'd0);
        check("rst_rsp_len",     67'(rsp_len),     67'd0);
        check("rst_rsp_timeout", 67'(rsp_timeout), 67'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge sample_clk);

        // ---- poll 0x01, full 4-byte reply ----
        run_tx(8'h01, 1'b0, wave, hold_ok);
        check("poll_tx_wave",  wave, exp_wave(8'h01));
        check("poll_busy_rx",  67'(busy), 67'd1);
        check("poll_ready_rx", 67'(cmd_ready), 67'd0);
        repeat (4) @(negedge sample_clk);
        ctrl_byte(8'h80);
        ctrl_byte(8'h00);
        ctrl_byte(8'h05);
        ctrl_byte(8'hFB);
        ctrl_stop();
        wait_valid(20, n, seen);
        check("poll_valid_seen", 67'(seen), 67'd1);
        check("poll_rsp_data",   67'(rsp_data), 67'h800005FB);
        check("poll_rsp_len",    67'(rsp_len), 67'd4);
        check("poll_timeout",    67'(rsp_timeout), 67'd0);
        check("poll_busy_done",  67'(busy), 67'd0);
        @(negedge sample_clk);
        check("poll_valid_pulse", 67'(rsp_valid), 67'd0);
        check("poll_ready_after", 67'(cmd_ready), 67'd1);
        check("poll_data_held",   67'(rsp_data), 67'h800005FB);
        repeat (2) @(negedge sample_clk);

        // ---- info 0x00 with cmd_valid held high while busy ----
        run_tx(8'h00, 1'b1, wave, hold_ok);
        check("info_tx_wave",    wave, exp_wave(8'h00));
        check("info_busy_ready", 67'(hold_ok), 67'd1);
        repeat (3) @(negedge sample_clk);
        ctrl_byte(8'h05);
        ctrl_byte(8'h00);
        ctrl_byte(8'h02);
        ctrl_stop();
        wait_valid(20, n, seen);
        check("info_valid_seen", 67'(seen), 67'd1);
        check("info_rsp_data",   67'(rsp_data), 67'h00050002);
        check("info_rsp_len",    67'(rsp_len), 67'd3);
        check("info_timeout",    67'(rsp_timeout), 67'd0);
        repeat (3) @(negedge sample_clk);
        check("info_no_requeue", 67'({busy, cmd_ready}), 67'b01);

        // ---- poll with no reply: timeout 128 cycles after release ----
        run_tx(8'h01, 1'b0, wave, hold_ok);
        check("noreply_release", 67'(data_tx), 67'd1);
        wait_valid(200, n, seen);
        check("noreply_valid_seen", 67'(seen), 67'd1);
        check("noreply_latency",    67'(n), 67'd128);
        check("noreply_timeout",    67'(rsp_timeout), 67'd1);
        check("noreply_len",        67'(rsp_len), 67'd0);
        check("noreply_data",       67'(rsp_data), 67'd0);
        repeat (2) @(negedge sample_clk);

        // ---- truncated reply: 2 bytes and 3 stray bits, no stop ----
        run_tx(8'h01, 1'b0, wave, hold_ok);
        repeat (4) @(negedge sample_clk);
        ctrl_byte(8'h80);
        ctrl_byte(8'h00);
        ctrl_bit(1'b1);
        ctrl_bit(1'b0);
        ctrl_bit(1'b1);
        wait_valid(300, n, seen);
        check("trunc_valid_seen", 67'(seen), 67'd1);
        check("trunc_len",        67'(rsp_len), 67'd2);
        check("trunc_data",       67'(rsp_data), 67'h00008000);
        check("trunc_timeout",    67'(rsp_timeout), 67'd1);
        repeat (2) @(negedge sample_clk);

        // ---- asynchronous reset in the middle of a TX low phase ----
        cmd_valid = 1'b1;
        cmd_byte  = 8'h00;
        @(negedge sample_clk);
        cmd_valid = 1'b0;
        @(negedge sample_clk);
        check("midrst_pulling", 67'(data_tx), 67'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_data_tx", 67'(data_tx), 67'd1);
        check("midrst_busy",    67'(busy), 67'd0);
        check("midrst_ready",   67'(cmd_ready), 67'd1);
        @(negedge sample_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge sample_clk);

        // ---- unknown command: zero reply bytes, done right after stop ----
        run_tx(8'h5A, 1'b0, wave, hold_ok);
        check("other_tx_wave",  wave[65:0], exp_wave(8'h5A) & 67'h3FFFFFFFFFFFFFFFF);
        check("other_valid",    67'(rsp_valid), 67'd1);
        check("other_len",      67'(rsp_len), 67'd0);
        check("other_timeout",  67'(rsp_timeout), 67'd0);
        @(negedge sample_clk);
        check("other_ready",    67'(cmd_ready), 67'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
